// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its key arbiter.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE
    } scan_state_t;

    // Widest pending vector the arbiter helper can search.
    localparam int MAX_KEYS = 256;

    function automatic int num_keys(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int lowest_set_index(input logic [MAX_KEYS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_cell.sv
// One key's debouncer: saturating disagreement counter, debounced level and
// a registered one-cycle pulse on each 0->1 transition.
module key_debounce_cell #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample_en,
    input  logic sample,
    output logic level,
    output logic press,
    output logic rise
);

    localparam int CNT_W = $clog2(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             flip;

    always_comb begin
        cnt_next = cnt_reg;
        flip     = 1'b0;
        if (sample_en) begin
            if (sample == level) begin
                cnt_next = '0;
            end else if (cnt_reg >= CNT_LAST) begin
                flip     = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
        // A flip towards the sampled 1 is a new press; a clear suppresses it.
        rise = flip && sample && !clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else if (clear) begin
            cnt_reg <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            level   <= level ^ flip;
            press   <= rise;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad front end: column scan FSM, per-key debounce, pending press
// vector and a single valid/ready output slot serving the lowest pending key.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [ROWS-1:0]                row_i,
    output logic [COLS-1:0]                col_o,
    output logic [ROWS*COLS-1:0]           key_state_o,
    output logic [ROWS*COLS-1:0]           key_press_o,
    output logic [$clog2(ROWS*COLS)-1:0]   key_code_o,
    output logic                           key_valid_o,
    input  logic                           key_ready_i
);

    localparam int KEYS     = num_keys(ROWS, COLS);
    localparam int CODE_W   = $clog2(KEYS);
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [COL_W-1:0]    LAST_COL    = COL_W'(COLS - 1);
    localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);

    scan_state_t         state_reg, state_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [SETTLE_W-1:0] settle_reg, settle_next;
    logic                sample_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        settle_next = settle_reg;
        sample_fire = 1'b0;
        col_o       = '0;
        // Column drive follows the registered state, so it drops one edge after en.
        if (state_reg == DRIVE || state_reg == SAMPLE) begin
            col_o = COLS'(1) << col_reg;
        end
        if (!en) begin
            state_next  = IDLE;
            col_next    = '0;
            settle_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next  = DRIVE;
                    col_next    = '0;
                    settle_next = '0;
                end
                DRIVE: begin
                    if (settle_reg == LAST_SETTLE) begin
                        state_next  = SAMPLE;
                        settle_next = '0;
                    end else begin
                        settle_next = settle_reg + 1'b1;
                    end
                end
                SAMPLE: begin
                    sample_fire = 1'b1;
                    state_next  = DRIVE;
                    col_next    = (col_reg == LAST_COL) ? '0 : col_reg + 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    logic [KEYS-1:0] key_rise;

    for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
        localparam int KEY_COL = gi / ROWS;
        localparam int KEY_ROW = gi % ROWS;

        key_debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .clear    (!en),
            .sample_en(sample_fire && (col_reg == COL_W'(KEY_COL))),
            .sample   (row_i[KEY_ROW]),
            .level    (key_state_o[gi]),
            .press    (key_press_o[gi]),
            .rise     (key_rise[gi])
        );
    end

    logic [KEYS-1:0]   pending_reg, pending_next;
    logic              load;
    logic [CODE_W-1:0] load_code;

    always_comb begin
        load      = (!key_valid_o || key_ready_i) && (|pending_reg);
        load_code = CODE_W'(lowest_set_index(MAX_KEYS'(pending_reg)));
        pending_next = pending_reg;
        if (load) begin
            pending_next[load_code] = 1'b0;
        end
        // New presses land after the load decision, so they wait a cycle.
        pending_next = pending_next | key_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            key_valid_o <= 1'b0;
            key_code_o  <= '0;
        end else if (!en) begin
            pending_reg <= '0;
            key_valid_o <= 1'b0;
            key_code_o  <= '0;
        end else begin
            pending_reg <= pending_next;
            if (load) begin
                key_valid_o <= 1'b1;
                key_code_o  <= load_code;
            end else if (key_ready_i) begin
                key_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scenario bench for keypad_scan_debounce: a key-matrix model feeds row_i and a
// scoreboard queue holds the key codes expected at the valid/ready handshake.
module tb_keypad_scan_debounce;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int SETTLE = 2;
    localparam int STABLE = 3;
    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = 4;
    localparam int FRAME  = COLS * (SETTLE + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [ROWS-1:0]   row_i;
    logic [COLS-1:0]   col_o;
    logic [KEYS-1:0]   key_state_o;
    logic [KEYS-1:0]   key_press_o;
    logic [CODE_W-1:0] key_code_o;
    logic              key_valid_o;
    logic              key_ready_i;

    logic [KEYS-1:0]   pressed;
    int                vectors = 0;
    int                miscompares = 0;
    int                exp_q[$];
    logic [COLS-1:0]   run_col = '0;
    int                run_len = 0;
    bit                sample_edge = 1'b0;
    int                sample_col = 0;

    keypad_scan_debounce #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .STABLE_SAMPLES(STABLE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .row_i(row_i), .col_o(col_o),
        .key_state_o(key_state_o), .key_press_o(key_press_o),
        .key_code_o(key_code_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to the currently driven column.
    always_comb begin
        row_i = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (col_o[c] && pressed[c*ROWS+r]) row_i[r] = 1'b1;
    end

    // Advance one clock; score any handshake and flag column sample edges.
    task automatic step();
        logic [COLS-1:0]   c;
        logic              v, r;
        logic [CODE_W-1:0] code;
        int                e;
        c = col_o; v = key_valid_o; r = key_ready_i; code = key_code_o;
        @(posedge clk);
        if (v && r) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL accept_unexpected: got code %0d, expected no report", code);
            end else begin
                e = exp_q.pop_front();
                if (code !== CODE_W'(e)) begin
                    miscompares++;
                    $display("FAIL accept_code: got %0d, expected %0d", code, e);
                end else begin
                    $display("accept key %0d at %0t", code, $time);
                end
            end
        end
        if (c != '0 && c == run_col) run_len++;
        else begin
            run_col = c;
            run_len = (c != '0) ? 1 : 0;
        end
        sample_edge = 1'b0;
        if (run_len == SETTLE + 1) begin
            sample_edge = 1'b1;
            run_len = 0;
            for (int i = 0; i < COLS; i++) if (c[i]) sample_col = i;
        end
        #1;
    endtask

    task automatic align_frame();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (sample_edge && sample_col == COLS - 1) return;
        end
        vectors++; miscompares++;
        $display("FAIL align_timeout: got no last-column sample edge, expected one within %0d cycles", 2 * FRAME);
    endtask

    task automatic release_all();
        pressed = '0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            vectors++;
            if (key_press_o !== '0) begin
                miscompares++;
                $display("FAIL release_pulse: got press %h, expected 0", key_press_o);
            end
        end
        vectors++;
        if (key_state_o !== '0) begin
            miscompares++;
            $display("FAIL release_state: got %h, expected 0", key_state_o);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [COLS-1:0] exp_col;
        rst = 1'b1; en = 1'b1; key_ready_i = 1'b1; pressed = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (col_o !== '0 || key_state_o !== '0 || key_press_o !== '0 || key_valid_o !== 1'b0 || key_code_o !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got col %b state %h press %h valid %b code %0d, expected all 0",
                     col_o, key_state_o, key_press_o, key_valid_o, key_code_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (col_o !== '0) begin
            miscompares++;
            $display("FAIL reset_idle_col: got %b, expected 0000", col_o);
        end
        for (int k = 1; k <= FRAME; k++) begin
            step();
            exp_col = COLS'(1) << (((k - 1) / (SETTLE + 1)) % COLS);
            vectors++;
            if (col_o !== exp_col) begin
                miscompares++;
                $display("FAIL col_walk: cycle %0d got %b, expected %b", k, col_o, exp_col);
            end
            vectors++;
            if (key_state_o !== '0 || key_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_keys: got state %h valid %b, expected 0 0", key_state_o, key_valid_o);
            end
        end
    endtask

    task automatic test_single_press();
        int n; bit fresh; bit done;
        align_frame();
        key_ready_i = 1'b1;
        pressed[9] = 1'b1;
        exp_q.push_back(9);
        n = 0; done = 1'b0;
        for (int i = 0; i < 5 * FRAME && !done; i++) begin
            step();
            if (sample_edge && sample_col == 2) n++;
            fresh = sample_edge && sample_col == 2 && n == STABLE;
            vectors++;
            if (key_state_o[9] !== (n >= STABLE)) begin
                miscompares++;
                $display("FAIL single_state: got %b after %0d samples, expected %b", key_state_o[9], n, n >= STABLE);
            end
            vectors++;
            if (key_press_o !== (fresh ? 16'h0200 : 16'h0000)) begin
                miscompares++;
                $display("FAIL single_pulse: got %h after %0d samples, expected %h", key_press_o, n, fresh ? 16'h0200 : 16'h0000);
            end
            if (fresh) begin
                step();
                vectors++;
                if (key_valid_o !== 1'b1 || key_code_o !== 4'd9 || key_press_o !== '0) begin
                    miscompares++;
                    $display("FAIL single_valid: got valid %b code %0d press %h, expected 1 9 0", key_valid_o, key_code_o, key_press_o);
                end
                done = 1'b1;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL single_timeout: got no press for key 9, expected one within %0d cycles", 5 * FRAME);
        end
        release_all();
    endtask

    task automatic test_bounce();
        int n;
        align_frame();
        key_ready_i = 1'b1;
        pressed[9] = 1'b1;
        n = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (n == 2) pressed[9] = 1'b0;
            step();
            if (sample_edge && sample_col == 2) n++;
            vectors++;
            if (key_state_o[9] !== 1'b0 || key_press_o !== '0 || key_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce: got state %b press %h valid %b, expected 0 0 0", key_state_o[9], key_press_o, key_valid_o);
            end
        end
        release_all();
    endtask

    task automatic test_backpressure();
        bit seen;
        align_frame();
        key_ready_i = 1'b0;
        pressed[2] = 1'b1; pressed[5] = 1'b1;
        exp_q.push_back(2); exp_q.push_back(5);
        seen = 1'b0;
        for (int i = 0; i < 5 * FRAME && !seen; i++) begin
            step();
            seen = key_valid_o;
        end
        vectors++;
        if (key_valid_o !== 1'b1 || key_code_o !== 4'd2) begin
            miscompares++;
            $display("FAIL bp_first: got valid %b code %0d, expected 1 2", key_valid_o, key_code_o);
        end
        seen = 1'b0;
        for (int i = 0; i < FRAME && !seen; i++) begin
            step();
            seen = key_state_o[5];
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (key_valid_o !== 1'b1 || key_code_o !== 4'd2) begin
                miscompares++;
                $display("FAIL bp_hold: got valid %b code %0d, expected 1 2", key_valid_o, key_code_o);
            end
        end
        key_ready_i = 1'b1;
        step();
        key_ready_i = 1'b0;
        vectors++;
        if (key_valid_o !== 1'b1 || key_code_o !== 4'd5) begin
            miscompares++;
            $display("FAIL bp_second: got valid %b code %0d, expected 1 5", key_valid_o, key_code_o);
        end
        step();
        vectors++;
        if (key_valid_o !== 1'b1 || key_code_o !== 4'd5) begin
            miscompares++;
            $display("FAIL bp_second_hold: got valid %b code %0d, expected 1 5", key_valid_o, key_code_o);
        end
        key_ready_i = 1'b1;
        step();
        key_ready_i = 1'b0;
        vectors++;
        if (key_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got valid %b, expected 0", key_valid_o);
        end
        release_all();
    endtask

    task automatic test_repress();
        bit seen;
        align_frame();
        key_ready_i = 1'b0;
        pressed[9] = 1'b1;
        exp_q.push_back(9);
        seen = 1'b0;
        for (int i = 0; i < 5 * FRAME && !seen; i++) begin step(); seen = key_valid_o; end
        pressed[9] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 * FRAME && !seen; i++) begin step(); seen = !key_state_o[9]; end
        pressed[9] = 1'b1;
        exp_q.push_back(9);
        seen = 1'b0;
        for (int i = 0; i < 5 * FRAME && !seen; i++) begin step(); seen = key_press_o[9]; end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL repress_timeout: got no second press of key 9, expected one");
        end
        vectors++;
        if (key_valid_o !== 1'b1 || key_code_o !== 4'd9) begin
            miscompares++;
            $display("FAIL repress_slot: got valid %b code %0d, expected 1 9", key_valid_o, key_code_o);
        end
        step();
        key_ready_i = 1'b1;
        step();
        vectors++;
        if (key_valid_o !== 1'b1 || key_code_o !== 4'd9) begin
            miscompares++;
            $display("FAIL repress_again: got valid %b code %0d, expected 1 9", key_valid_o, key_code_o);
        end
        step();
        vectors++;
        if (key_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL repress_drain: got valid %b, expected 0", key_valid_o);
        end
        release_all();
    endtask

    task automatic test_enable_drop();
        bit seen; int n;
        align_frame();
        key_ready_i = 1'b0;
        pressed[3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 * FRAME && !seen; i++) begin step(); seen = key_valid_o; end
        vectors++;
        if (key_valid_o !== 1'b1 || key_code_o !== 4'd3 || key_state_o[3] !== 1'b1 || col_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL en_setup: got valid %b code %0d state %b col %b, expected 1 3 1 0010",
                     key_valid_o, key_code_o, key_state_o[3], col_o);
        end
        en = 1'b0;
        step();
        vectors++;
        if (col_o !== '0 || key_state_o !== '0 || key_valid_o !== 1'b0 || key_press_o !== '0) begin
            miscompares++;
            $display("FAIL en_clear: got col %b state %h valid %b press %h, expected all 0",
                     col_o, key_state_o, key_valid_o, key_press_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (col_o !== '0 || key_press_o !== '0) begin
                miscompares++;
                $display("FAIL en_idle: got col %b press %h, expected 0 0", col_o, key_press_o);
            end
        end
        en = 1'b1;
        key_ready_i = 1'b1;
        exp_q.push_back(3);
        n = 0;
        for (int i = 0; i < 3 * FRAME + 4; i++) begin
            step();
            if (i == 0) begin
                vectors++;
                if (col_o !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL en_restart: got col %b, expected 0001", col_o);
                end
            end
            if (sample_edge && sample_col == 0) n++;
            vectors++;
            if (key_state_o[3] !== (n >= STABLE)) begin
                miscompares++;
                $display("FAIL en_redebounce: got %b after %0d samples, expected %b", key_state_o[3], n, n >= STABLE);
            end
        end
        release_all();
    endtask

    task automatic test_async_reset();
        bit seen;
        align_frame();
        key_ready_i = 1'b0;
        pressed[6] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 * FRAME && !seen; i++) begin step(); seen = key_valid_o; end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (col_o !== '0 || key_state_o !== '0 || key_valid_o !== 1'b0 || key_code_o !== '0 || key_press_o !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got col %b state %h valid %b code %0d press %h, expected all 0",
                     col_o, key_state_o, key_valid_o, key_code_o, key_press_o);
        end
        pressed = '0;
        step(); step();
        rst = 1'b0;
        step();
        vectors++;
        if (col_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_restart: got col %b, expected 0001", col_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected one before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_backpressure();
        test_repress();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
